// File: rtl/note_sequencer_if.sv
// Note command bus between the SPI receiver and the note sequencer.
// master: cmdValid/cmdTune/cmdVol/cmdDur out, cmdReady in; slave mirrors.
interface note_sequencer_if;
    logic        cmdValid;
    logic [15:0] cmdTune;
    logic [7:0]  cmdVol;
    logic [15:0] cmdDur;
    logic        cmdReady;

    modport master (
        output cmdValid,
        output cmdTune,
        output cmdVol,
        output cmdDur,
        input  cmdReady
    );

    modport slave (
        input  cmdValid,
        input  cmdTune,
        input  cmdVol,
        input  cmdDur,
        output cmdReady
    );
endinterface

// File: rtl/note_sequencer.sv
// Note sequencer: FIFO of {tune, vol, dur} commands played back-to-back
// with a linear attack/release envelope, timed by the sample-rate tick.
// Ports: clk, reset (async active-low), tick, flush, cmd (slave bus),
// tuneWord/volume to the wave generator, busy, overflow (sticky).
module note_sequencer #(
    parameter int DEPTH     = 4,
    parameter int RAMP_STEP = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               flush,
    note_sequencer_if.slave    cmd,
    output logic [15:0]        tuneWord,
    output logic [7:0]         volume,
    output logic               busy,
    output logic               overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        SUSTAIN,
        RELEASE
    } stateT;

    // Reset asserts asynchronously, releases after two clk edges.
    logic [1:0] rstSync;
    logic       rstN;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rstSync <= 2'b00;
        else        rstSync <= {rstSync[0], 1'b1};
    end

    assign rstN = rstSync[1];

    logic [39:0]   mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          drop;
    logic          pop;
    logic [15:0]   headTune;
    logic [7:0]    headVol;
    logic [15:0]   headDur;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign cmd.cmdReady = ~full;
    assign push         = cmd.cmdValid & ~full & ~flush;
    assign drop         = cmd.cmdValid & full & ~flush;
    assign headTune     = mem[rdPtr][39:24];
    assign headVol      = mem[rdPtr][23:16];
    assign headDur      = mem[rdPtr][15:0];

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= {cmd.cmdTune, cmd.cmdVol, cmd.cmdDur};
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (drop) overflow <= 1'b1;
        end
    end

    stateT       state;
    stateT       stateNext;
    logic [7:0]  target;
    logic [7:0]  targetNext;
    logic [15:0] durCnt;
    logic [15:0] durNext;
    logic [7:0]  volNext;
    logic [15:0] tuneNext;
    logic [8:0]  upSum;

    // 9-bit sum so the attack step clamps at target instead of wrapping.
    assign upSum = {1'b0, volume} + 9'(RAMP_STEP);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            volume   <= '0;
            tuneWord <= '0;
            target   <= '0;
            durCnt   <= '0;
        end else begin
            state    <= stateNext;
            volume   <= volNext;
            tuneWord <= tuneNext;
            target   <= targetNext;
            durCnt   <= durNext;
        end
    end

    always_comb begin
        stateNext  = state;
        volNext    = volume;
        tuneNext   = tuneWord;
        targetNext = target;
        durNext    = durCnt;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && !flush) begin
                    pop        = 1'b1;
                    stateNext  = ATTACK;
                    tuneNext   = headTune;
                    targetNext = headVol;
                    durNext    = headDur;
                    volNext    = '0;
                end
            end
            ATTACK: begin
                if (flush) begin
                    stateNext = RELEASE;
                end else if (tick) begin
                    if (upSum >= {1'b0, target}) begin
                        volNext   = target;
                        stateNext = SUSTAIN;
                    end else begin
                        volNext = upSum[7:0];
                    end
                end
            end
            SUSTAIN: begin
                if (flush) begin
                    stateNext = RELEASE;
                end else if (tick) begin
                    if (durCnt == '0) stateNext = RELEASE;
                    else              durNext   = durCnt - 1'b1;
                end
            end
            RELEASE: begin
                if (tick) begin
                    if (volume <= 8'(RAMP_STEP)) begin
                        volNext   = '0;
                        tuneNext  = '0;
                        stateNext = IDLE;
                    end else begin
                        volNext = volume - 8'(RAMP_STEP);
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state != IDLE) | ~empty;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: envelope, FIFO, flush, reset.
// Expected values are hand-computed for DEPTH=4, RAMP_STEP=8.
module tb_note_sequencer;
    logic        clk;
    logic        reset;
    logic        tick;
    logic        flush;
    logic [15:0] tuneWord;
    logic [7:0]  volume;
    logic        busy;
    logic        overflow;
    int          checks;
    int          errors;
    bit          done;

    int sat[17] = '{8, 16, 24, 32, 40, 48, 56, 60, 60,
                    52, 44, 36, 28, 20, 12, 4, 0};

    note_sequencer_if bus ();

    note_sequencer #(.DEPTH(4), .RAMP_STEP(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .flush    (flush),
        .cmd      (bus),
        .tuneWord (tuneWord),
        .volume   (volume),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tk();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic push(input logic [15:0] t, input logic [7:0] v,
                        input logic [15:0] d);
        bus.cmdValid = 1'b1;
        bus.cmdTune  = t;
        bus.cmdVol   = v;
        bus.cmdDur   = d;
        cyc();
        bus.cmdValid = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        done         = 1'b0;
        reset        = 1'b1;
        tick         = 1'b0;
        flush        = 1'b0;
        bus.cmdValid = 1'b0;
        bus.cmdTune  = '0;
        bus.cmdVol   = '0;
        bus.cmdDur   = '0;
        #2 reset = 1'b0;
        repeat (3) cyc();
        check("rst_tune", 32'(tuneWord), 0);
        check("rst_vol", 32'(volume), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_ready", 32'(bus.cmdReady), 1);
        reset = 1'b1;
        repeat (4) cyc();

        // Single note: attack 8..64, hold 4 ticks, release to 0.
        push(16'h1000, 8'd64, 16'd3);
        check("n1_busy", 32'(busy), 1);
        check("n1_tune_pre", 32'(tuneWord), 0);
        cyc();
        check("n1_tune", 32'(tuneWord), 32'h1000);
        check("n1_vol0", 32'(volume), 0);
        for (int i = 1; i <= 20; i++) begin
            int e;
            tk();
            if (i <= 8)       e = 8 * i;
            else if (i <= 12) e = 64;
            else              e = 64 - 8 * (i - 12);
            check($sformatf("n1_vol_t%0d", i), 32'(volume), 32'(e));
            if (i == 19) check("n1_tune_t19", 32'(tuneWord), 32'h1000);
        end
        check("n1_tune_end", 32'(tuneWord), 0);
        check("n1_busy_end", 32'(busy), 0);

        // Saturating envelope with target 60.
        push(16'h1100, 8'd60, 16'd0);
        cyc();
        for (int i = 0; i < 17; i++) begin
            tk();
            check($sformatf("sat_t%0d", i + 1), 32'(volume), 32'(sat[i]));
        end
        check("sat_idle", 32'(busy), 0);

        // Zero-volume note stays silent and ends on its own.
        push(16'h1200, 8'd0, 16'd2);
        cyc();
        begin
            int n;
            n = 0;
            while (busy && n < 10) begin
                tk();
                n++;
                check("zero_vol", 32'(volume), 0);
            end
            check("zero_ends", 32'(busy), 0);
        end
        check("zero_tune", 32'(tuneWord), 0);

        // Flush mid-sustain with 2 queued plus a same-cycle push.
        push(16'h4000, 8'd64, 16'd50);
        cyc();
        repeat (10) tk();
        check("fl_sus", 32'(volume), 64);
        push(16'h5000, 8'd32, 16'd1);
        push(16'h5001, 8'd32, 16'd1);
        flush        = 1'b1;
        bus.cmdValid = 1'b1;
        bus.cmdTune  = 16'h6000;
        bus.cmdVol   = 8'd16;
        bus.cmdDur   = 16'd1;
        cyc();
        flush        = 1'b0;
        bus.cmdValid = 1'b0;
        check("fl_ovf", 32'(overflow), 0);
        check("fl_vol_hold", 32'(volume), 64);
        for (int i = 1; i <= 8; i++) begin
            tk();
            check($sformatf("fl_rel_t%0d", i), 32'(volume),
                  32'(64 - 8 * i));
        end
        check("fl_tune0", 32'(tuneWord), 0);
        repeat (3) cyc();
        check("fl_busy", 32'(busy), 0);
        check("fl_tune_idle", 32'(tuneWord), 0);

        // Overflow: long note, then 6 pushes into a 4-deep FIFO.
        push(16'h2000, 8'd16, 16'd100);
        cyc();
        for (int k = 1; k <= 6; k++) begin
            push(16'h3000 + 16'(k), 8'd8, 16'd0);
            if (k == 3) check("of_rdy3", 32'(bus.cmdReady), 1);
            if (k == 4) check("of_rdy4", 32'(bus.cmdReady), 0);
            if (k == 4) check("of_ovf4", 32'(overflow), 0);
        end
        check("of_ovf6", 32'(overflow), 1);
        repeat (104) tk();
        check("of_long_v", 32'(volume), 8);
        check("of_long_t", 32'(tuneWord), 32'h2000);
        tk();
        check("of_long_end", 32'(tuneWord), 0);
        check("of_full_rdy", 32'(bus.cmdReady), 0);
        // Push coinciding with the pop from a full FIFO is dropped.
        bus.cmdValid = 1'b1;
        bus.cmdTune  = 16'h3007;
        bus.cmdVol   = 8'd8;
        bus.cmdDur   = 16'd0;
        cyc();
        bus.cmdValid = 1'b0;
        check("of_rdy_pop", 32'(bus.cmdReady), 1);
        for (int n = 1; n <= 4; n++) begin
            if (n > 1) cyc();
            check($sformatf("of_tune%0d", n), 32'(tuneWord),
                  32'h3000 + 32'(n));
            tk();
            check($sformatf("of_vol%0d", n), 32'(volume), 8);
            tk();
            tk();
            check($sformatf("of_end%0d", n), 32'(tuneWord), 0);
        end
        cyc();
        check("of_busy", 32'(busy), 0);
        check("of_tune_last", 32'(tuneWord), 0);
        check("of_sticky", 32'(overflow), 1);

        // Async reset mid-attack with a note queued.
        push(16'h7000, 8'd64, 16'd3);
        cyc();
        push(16'h7100, 8'd64, 16'd3);
        repeat (3) tk();
        check("ar_vol", 32'(volume), 24);
        #2 reset = 1'b0;
        #1;
        check("ar_vol0", 32'(volume), 0);
        check("ar_tune0", 32'(tuneWord), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_ovf", 32'(overflow), 0);
        check("ar_rdy", 32'(bus.cmdReady), 1);
        cyc();
        reset = 1'b1;
        repeat (4) cyc();
        check("ar_queue", 32'(busy), 0);
        push(16'h8000, 8'd8, 16'd0);
        cyc();
        check("ar_new_tune", 32'(tuneWord), 32'h8000);
        tk();
        check("ar_new_vol", 32'(volume), 8);
        tk();
        tk();
        check("ar_new_end", 32'(tuneWord), 0);
        check("ar_new_busy", 32'(busy), 0);

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            errors++;
            $display("FAIL timeout got running want done");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "timeout");
        end
    end
endmodule
